// File: rtl/ascii_stream_ctrl_pkg.sv
// Shared types and character constants for the ASCII stream controller.
package ascii_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GEN   = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_QMARK     = 8'h3F;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

  // Non-printable characters are replaced so the display never shows control codes.
  function automatic logic [7:0] printable_or_qmark(input logic [7:0] ch);
    return (ch >= ASCII_PRINT_MIN && ch <= ASCII_PRINT_MAX) ? ch : ASCII_QMARK;
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor: row/column position plus the matching linear buffer address.
module text_cursor #(
  parameter int COLS   = 40,
  parameter int ROWS   = 15,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     advance,
  input  logic                     home,
  output logic [$clog2(ROWS)-1:0]  row,
  output logic [$clog2(COLS)-1:0]  col,
  output logic [ADDR_W-1:0]        addr
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic last_col;
  logic last_row;

  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));

  // addr tracks row*COLS+col incrementally so no multiplier is needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (home) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        if (last_row) begin
          row  <= '0;
          addr <= '0;
        end else begin
          row  <= row + RW'(1);
          addr <= addr + ADDR_W'(1);
        end
      end else begin
        col  <= col + CW'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/ascii_stream_ctrl.sv
// Streams generator characters into a COLS x ROWS text buffer, with a blanking
// (clear) sequence and a run-length-bounded generation mode.
module ascii_stream_ctrl
  import ascii_stream_ctrl_pkg::*;
#(
  parameter int COLS   = 40,
  parameter int ROWS   = 15,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic [11:0]              run_len,
  output logic                     gen_execute,
  input  logic                     gen_valid,
  input  logic [7:0]               gen_ascii,
  output logic                     buf_we,
  output logic [ADDR_W-1:0]        buf_addr,
  output logic [7:0]               buf_wdata,
  output logic                     busy,
  output logic                     done,
  output logic [11:0]              char_count,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output state_e                   dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  // Generator handshake: gen_execute is the ready side, gen_valid the valid side.
  // A character transfers on every clock edge where both are high; there is no
  // other backpressure, and gen_valid while gen_execute is low is discarded.

  state_e             state_q, state_d;
  logic [11:0]        run_len_q;
  logic [11:0]        count_next;
  logic [ADDR_W-1:0]  cur_addr;
  logic               cur_advance, cur_home;
  logic               wr_issue;
  logic [7:0]         wr_data;
  logic               count_clr, accept;

  text_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (cur_advance),
    .home    (cur_home),
    .row     (cursor_row),
    .col     (cursor_col),
    .addr    (cur_addr)
  );

  assign count_next  = (char_count == 12'hFFF) ? char_count : char_count + 12'd1;
  assign gen_execute = (state_q == ST_GEN);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign dbg_state   = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cur_advance = 1'b0;
    cur_home    = 1'b0;
    wr_issue    = 1'b0;
    wr_data     = ASCII_SPACE;
    count_clr   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          cur_home  = 1'b1;
          count_clr = 1'b1;
        end else if (start) begin
          if (run_len != 12'd0) begin
            state_d   = ST_GEN;
            count_clr = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_CLEAR: begin
        // Leave only once the last blank is on the bus so done trails it by a cycle.
        if (buf_we && buf_addr == LAST_ADDR) begin
          state_d = ST_FIN;
        end else begin
          wr_issue    = 1'b1;
          cur_advance = 1'b1;
        end
      end
      ST_GEN: begin
        if (gen_valid) begin
          accept      = 1'b1;
          wr_issue    = 1'b1;
          wr_data     = printable_or_qmark(gen_ascii);
          cur_advance = 1'b1;
          if (count_next == run_len_q) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      char_count <= '0;
      run_len_q  <= '0;
    end else begin
      buf_we <= wr_issue;
      if (wr_issue) begin
        buf_addr  <= cur_addr;
        buf_wdata <= wr_data;
      end
      if (count_clr) begin
        char_count <= '0;
        run_len_q  <= run_len;
      end else if (accept) begin
        char_count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_ascii_stream_ctrl.sv
// Randomized bench for ascii_stream_ctrl on a 4x2 buffer, checked against a
// linear-position reference model of the text buffer.
module tb_ascii_stream_ctrl;
  import ascii_stream_ctrl_pkg::*;

  localparam int COLS = 4, ROWS = 2, ADDR_W = 10;
  localparam int DEPTH = COLS * ROWS;
  localparam int EW = ADDR_W + 8;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, clear = 1'b0, gen_valid = 1'b0;
  logic [11:0] run_len = '0;
  logic [7:0]  gen_ascii = '0;
  logic gen_execute, buf_we, busy, done;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0] buf_wdata;
  logic [11:0] char_count;
  logic [0:0] cursor_row;
  logic [1:0] cursor_col;
  state_e dbg_state;

  int errors = 0, checks = 0, cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_q[$];
  int wcyc_q[$];
  int done_cyc = -1, done_cnt = 0;
  logic done_gx = 1'b0;
  logic [7:0] chars[$];
  int m_pos = 0, m_count = 0;

  ascii_stream_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear), .run_len(run_len),
    .gen_execute(gen_execute), .gen_valid(gen_valid), .gen_ascii(gen_ascii),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .busy(busy),
    .done(done), .char_count(char_count), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Write/done monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (buf_we) begin
        act_q.push_back({buf_addr, buf_wdata});
        wcyc_q.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        done_gx  = gen_execute;
        done_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_char(input logic [7:0] c);
    int v;
    v = c;
    return (v >= 32 && v <= 126) ? c : 8'd63;
  endfunction

  task automatic model_run(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({ADDR_W'(m_pos), m_char(chars[k])});
      m_pos = (m_pos + 1) % DEPTH;
    end
    m_count = (n > 4095) ? 4095 : n;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), 8'h20});
    m_pos = 0;
    m_count = 0;
  endtask

  task automatic flush();
    exp_q.delete();
    act_q.delete();
    wcyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    step();
    start = 1'b1;
    run_len = 12'(len);
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // mode 0: continuous, 1: gap on every other cycle, 2: random gaps
  task automatic feed(input int mode);
    int k = 0, n = 0;
    bit gap;
    while (gen_execute && n < 200) begin
      gap = (mode == 1) ? (n % 2 == 0) : (mode == 2) ? ($urandom_range(0, 99) < 30) : 1'b0;
      if (gap) begin
        gen_valid = 1'b0;
        gen_ascii = 8'($urandom_range(0, 255));
      end else begin
        gen_valid = 1'b1;
        gen_ascii = (k < chars.size()) ? chars[k] : 8'h00;
        k++;
      end
      step();
      n++;
    end
    gen_valid = 1'b0;
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL feed_timeout: gen_execute still high after %0d cycles, required low", n);
    end
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done pulse within %0d cycles, required one", n);
    end
    step();
  endtask

  task automatic rand_chars(input int n, input bit printable);
    chars.delete();
    repeat (n) chars.push_back(printable ? 8'($urandom_range(32, 126)) : 8'($urandom_range(0, 255)));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    checks++; if ({gen_execute, buf_we, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b required 0000", {gen_execute, buf_we, busy, done}); end
    checks++; if (buf_addr !== '0 || buf_wdata !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h/%h required 0/0", buf_addr, buf_wdata); end
    checks++; if (char_count !== 12'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", char_count); end
    checks++; if (cursor_row !== 1'b0 || cursor_col !== 2'd0) begin errors++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
    // gen_valid in IDLE must be ignored
    repeat (6) begin
      gen_valid = 1'b1;
      gen_ascii = 8'($urandom_range(0, 255));
      step();
    end
    gen_valid = 1'b0;
    step();
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL idle_no_write: got %0d writes required 0", act_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
    flush();
  endtask

  task automatic test_clear();
    int base;
    base = done_cnt;
    pulse_clear();
    model_clear();
    wait_done(base);
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL clear_nwrites: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL clear_write[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    if (wcyc_q.size() > 0) begin
      checks++; if (done_cyc != wcyc_q[$] + 1) begin errors++; $display("FAIL clear_done_cycle: got %0d required %0d", done_cyc, wcyc_q[$] + 1); end
    end
    checks++; if (cursor_row !== 1'b0 || cursor_col !== 2'd0) begin errors++; $display("FAIL clear_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col); end
    flush();
  endtask

  task automatic test_run_basic();
    int base;
    chars.delete();
    for (int c = 8'h61; c <= 8'h65; c++) chars.push_back(8'(c));
    base = done_cnt;
    pulse_start(5);
    model_run(5);
    feed(0);
    wait_done(base);
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL run5_nwrites: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL run5_write[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    if (wcyc_q.size() > 0) begin
      checks++; if (done_cyc != wcyc_q[$]) begin errors++; $display("FAIL run5_done_with_write: got %0d required %0d", done_cyc, wcyc_q[$]); end
    end
    checks++; if (done_gx !== 1'b0) begin errors++; $display("FAIL run5_gen_execute_drop: got %b required 0", done_gx); end
    checks++; if (char_count !== 12'(m_count)) begin errors++; $display("FAIL run5_count: got %0d required %0d", char_count, m_count); end
    flush();
  endtask

  task automatic test_wrap();
    int base;
    base = done_cnt;
    pulse_clear();
    wait_done(base);
    model_clear();
    flush();
    for (int r = 0; r < 2; r++) begin
      rand_chars(6, 1'b1);
      base = done_cnt;
      pulse_start(6);
      model_run(6);
      feed(2);
      wait_done(base);
    end
    checks++; if (act_q.size() != 12) begin errors++; $display("FAIL wrap_nwrites: got %0d required 12", act_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (cursor_row !== 1'(m_pos / COLS) || cursor_col !== 2'(m_pos % COLS)) begin errors++; $display("FAIL wrap_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, m_pos / COLS, m_pos % COLS); end
    flush();
  endtask

  task automatic test_sanitize();
    int base, len;
    chars.delete();
    chars.push_back(8'h0A); chars.push_back(8'h41); chars.push_back(8'h7F);
    base = done_cnt;
    pulse_start(3);
    model_run(3);
    feed(1);
    wait_done(base);
    len = $urandom_range(1, 10);
    rand_chars(len, 1'b0);
    base = done_cnt;
    pulse_start(len);
    model_run(len);
    feed(2);
    wait_done(base);
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL sanitize_nwrites: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL sanitize_write[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    flush();
  endtask

  task automatic test_priority();
    int base, c0;
    // start and clear together: clear wins
    base = done_cnt;
    step();
    start = 1'b1; clear = 1'b1; run_len = 12'd3;
    step();
    start = 1'b0; clear = 1'b0;
    model_clear();
    wait_done(base);
    checks++; if (act_q.size() != DEPTH) begin errors++; $display("FAIL prio_nwrites: got %0d required %0d", act_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL prio_write[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (char_count !== 12'(m_count)) begin errors++; $display("FAIL prio_count: got %0d required %0d", char_count, m_count); end
    flush();
    // start and clear during GEN are ignored
    rand_chars(4, 1'b1);
    base = done_cnt;
    pulse_start(4);
    model_run(4);
    start = 1'b1; clear = 1'b1; run_len = 12'd1;
    step();
    start = 1'b0; clear = 1'b0;
    feed(0);
    wait_done(base);
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL ignore_nwrites: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL ignore_write[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (char_count !== 12'(m_count)) begin errors++; $display("FAIL ignore_count: got %0d required %0d", char_count, m_count); end
    flush();
    // zero-length run: done next cycle, nothing written
    base = done_cnt;
    step();
    start = 1'b1; run_len = 12'd0;
    c0 = cyc;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++; if (done_cnt != base + 1 || done_cyc != c0 + 1) begin errors++; $display("FAIL zero_done: got pulses=%0d cycle=%0d required 1 at %0d", done_cnt - base, done_cyc, c0 + 1); end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL zero_nwrites: got %0d required 0", act_q.size()); end
    checks++; if (char_count !== 12'(m_count)) begin errors++; $display("FAIL zero_count: got %0d required %0d", char_count, m_count); end
    flush();
  endtask

  task automatic test_back_to_back();
    int base, len;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 12);
      rand_chars(len, 1'b0);
      base = done_cnt;
      pulse_start(len);
      model_run(len);
      feed(2);
      wait_done(base);
      checks++; if (char_count !== 12'(m_count)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d required %0d", r, char_count, m_count); end
    end
    checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_nwrites: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (cursor_row !== 1'(m_pos / COLS) || cursor_col !== 2'(m_pos % COLS)) begin errors++; $display("FAIL b2b_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_row, cursor_col, m_pos / COLS, m_pos % COLS); end
    flush();
  endtask

  task automatic test_reset_mid();
    rand_chars(10, 1'b1);
    pulse_start(10);
    gen_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gen_ascii = chars[k];
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({gen_execute, buf_we, buf_addr, buf_wdata, busy, done, char_count, cursor_row, cursor_col} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got we=%b addr=%h data=%h busy=%b cnt=%0d exec=%b required all 0", buf_we, buf_addr, buf_wdata, busy, char_count, gen_execute);
    end
    flush();
    m_pos = 0; m_count = 0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();
    gen_valid = 1'b0;
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL midreset_no_write: got %0d writes required 0", act_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
    flush();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) step();
    test_reset();
    reset_n = 1'b1;
    step();
    test_reset();
    test_clear();
    test_run_basic();
    test_wrap();
    test_sanitize();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascii_stream_ctrl.md
ASCII_STREAM_CTRL -- requirements
Module: ascii_stream_ctrl

Interface
REQ-001 SHALL have parameters: COLS, default 40, text columns; ROWS, default 15, text rows; ADDR_W, default 10, buffer address width (COLS*ROWS <= 2**ADDR_W).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begin a generation run.
- clear  in  1  one-cycle pulse; blank the buffer and home the cursor.
- run_len  in  12  characters in the run, sampled at start.
- gen_execute  out  1  enable to the ASCII generator.
- gen_valid  in  1  generator character valid this cycle.
- gen_ascii  in  8  generator character.
- buf_we  out  1  text-buffer write strobe.
- buf_addr  out  ADDR_W  write address, row*COLS+col.
- buf_wdata  out  8  write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at run or clear completion.
- char_count  out  12  characters written in the current or last run.
- cursor_row  out  ceil(log2(ROWS))  next write row.
- cursor_col  out  ceil(log2(COLS))  next write column.

Function
REQ-003 SHALL implement the states IDLE, CLEAR, GEN and FIN.
REQ-004 IDLE: clear -> CLEAR; else start with run_len != 0 -> GEN; else start with run_len == 0 -> FIN; clear has priority when asserted together with start.
REQ-005 start and clear SHALL be ignored outside IDLE.
REQ-006 CLEAR SHALL write 0x20 to addresses 0..COLS*ROWS-1, one per cycle in ascending order.
- After the last write: cursor to (0,0), then -> FIN.
REQ-007 Entering GEN SHALL latch run_len and zero char_count.
- gen_execute SHALL be high in GEN only, and drop in the same cycle the final character is accepted.
REQ-008 In GEN, each cycle with gen_valid high SHALL accept one character.
- The write occurs the next cycle: buf_we=1, buf_addr=cursor at acceptance, buf_wdata=character.
- Write latency is exactly 1 cycle.
REQ-009 Accepted characters outside 0x20..0x7E SHALL be written as 0x3F.
REQ-010 Cursor advance per accepted character:
- col+1.
- At col=COLS-1: col=0, row+1.
- At row=ROWS-1 and col=COLS-1: wrap to (0,0).
REQ-011 char_count SHALL increment per accepted character, saturating at 4095.
- When char_count reaches the latched run_len -> FIN.
REQ-012 gen_valid outside GEN SHALL be ignored and produce no write.
REQ-013 FIN SHALL last one cycle with done=1, then -> IDLE.
- The final GEN write and the done pulse occur in the same cycle.
REQ-014 Cursor and char_count SHALL persist across runs until clear or reset.

Reset
REQ-015 On reset_n low, immediately and independent of clk:
- state=IDLE.
- All outputs 0: gen_execute, buf_we, buf_addr, buf_wdata, busy, done, char_count, cursor_row, cursor_col.
REQ-016 Reset mid-run or mid-clear SHALL abort with no further buf_we; buffer contents are undefined.

Structure
REQ-017 A shared package SHALL hold the state enum, ASCII_SPACE=0x20, ASCII_QMARK=0x3F, ASCII_PRINT_MIN=0x20 and ASCII_PRINT_MAX=0x7E.
REQ-018 Cursor and address arithmetic SHALL be in one sub-module, text_cursor.
- Inputs: advance, home.
- Outputs: row, col, linear address.

Verification
REQ-019 Reset then idle: all outputs 0, busy=0, no buf_we.
REQ-020 COLS=4, ROWS=2, clear: 8 writes of 0x20 at addresses 0..7, done on the cycle after the last write, cursor (0,0).
REQ-021 run_len=5, generator continuous 0x61..0x65: writes at addresses 0..4; done coincides with the 5th write; char_count=5; gen_execute low after the 5th acceptance.
REQ-022 COLS=4, ROWS=2, two runs of run_len=6: second run writes addresses 6,7,0,1,2,3; final cursor (1,0).
REQ-023 run_len=3, gen_ascii 0x0A, 0x41, 0x7F with gen_valid gapped: writes 0x3F, 0x41, 0x3F; no writes in gap cycles.
REQ-024 start and clear in the same IDLE cycle -> CLEAR only. start during GEN is ignored. run_len=0 start -> done next cycle with no writes. reset_n low mid-GEN -> outputs 0 immediately.
